lcd_cmd_host: RTL and testbench
===============================

Name: lcd_cmd_host

Overview:
Host-side command initiator for LCD_CTRL; it drives the cmd/cmd_valid/busy/done interface from the controller's opposite end.
- Buffers image-processing commands pushed by an upstream sequencer in a small FIFO.
- Issues each command to LCD_CTRL only when busy is low.
- After a Write command (code 0) it holds further issue until LCD_CTRL pulses done.
- It replaces the bench-style "drive when !busy" loop in the LCD subsystem top.

Parameters:
DEPTH, 8, command FIFO entries (power of two, 2..16)
ACK_TO, 4, cycles to wait for busy to rise after an issue before flagging ack_err

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; flushes FIFO and returns FSM to IDLE
in_cmd  in  4  command code from upstream
in_valid  in  1  upstream push strobe
in_ready  out  1  FIFO not full; a push happens when in_valid && in_ready
cmd  out  4  command to LCD_CTRL
cmd_valid  out  1  one-cycle issue strobe to LCD_CTRL
busy  in  1  LCD_CTRL busy
done  in  1  LCD_CTRL done pulse (image written to IRAM)
img_done  out  1  one-cycle pulse when done is seen in WAIT_DONE
bad_cmd  out  1  one-cycle pulse when an illegal code (12..15) is pushed
ack_err  out  1  sticky; set on ACK timeout, cleared only by reset
issue_cnt  out  8  commands issued since reset, saturates at 255

Behaviour:
- Reset values: cmd=0, cmd_valid=0, img_done=0, bad_cmd=0, ack_err=0, issue_cnt=0, FIFO empty, so in_ready=1 one cycle after reset deasserts.
  - Reset mid-operation aborts any wait state and discards queued commands.
- Legal codes are 0..11: 0 Write, 1 ShiftUp, 2 ShiftDown, 3 ShiftLeft, 4 ShiftRight, 5 Max, 6 Min, 7 Average, 8 RotCCW, 9 RotCW, 10 MirrorX, 11 MirrorY.
  - Codes 12..15 are accepted (in_ready honoured) but not stored; bad_cmd pulses the next cycle.
- in_ready = !full, computed from the current occupancy only. A push while full is refused even if a pop occurs in the same cycle.
- A push into an empty FIFO is visible to the FSM the following cycle; minimum push-to-cmd_valid latency is 2 cycles.
- Simultaneous push and pop with the FIFO non-full and non-empty leaves occupancy unchanged.
- FSM states:
  - IDLE: if FIFO non-empty and busy==0, register cmd=head, assert cmd_valid for exactly one cycle, pop, increment issue_cnt (saturating), then go to ACK. Otherwise stay.
  - ACK: wait for busy==1, then go to RUN.
    - If busy stays 0 for ACK_TO cycles, set ack_err and go to IDLE; a non-Write command is treated as complete.
    - If the issued command was Write, the timeout goes to WAIT_DONE instead.
  - RUN: wait for busy==0. Issued Write goes to WAIT_DONE; any other command goes to IDLE.
  - WAIT_DONE: wait for done==1, pulse img_done next cycle, go to IDLE. No issue occurs in this state; pushes continue to be accepted.
- cmd holds its last issued value while cmd_valid is 0.
- busy high at IDLE entry (e.g. LCD_CTRL's initial image load after reset) simply defers issue; no error.
- done observed outside WAIT_DONE is ignored.

Decomposition:
- lcd_pkg: 4-bit command code constants (CMD_WRITE..CMD_MIRRORY), CMD_LAST=11, FSM state enum {IDLE, ACK, RUN, WAIT_DONE}. Shared with LCD_CTRL.
- One sub-module: lcd_cmd_fifo (synchronous FIFO, DEPTH x 4 bits, registered occupancy count, full/empty flags, first-word-fall-through head).

Test Plan:
1. Reset, then push 1,4,0 with a behavioural LCD model (busy rises 1 cycle after issue, held 3 cycles; done 2 cycles after the Write busy falls) -> cmd_valid pulses 3 times with cmd 1,4,0, each only while busy==0. img_done pulses once. issue_cnt=3.
2. Push 9 pushes with DEPTH=8 and busy held high -> in_ready drops after 8 accepted. The 9th is refused. Release busy -> the 8 commands are issued in FIFO order.
3. Push 13 then 2 -> bad_cmd pulses once; only cmd=2 is issued; issue_cnt=1.
4. Model never raises busy after issuing 5 -> after 4 cycles ack_err=1 and stays 1. The next queued command 6 is still issued.
5. Push Write then 3; delay done 20 cycles -> cmd=3 is not issued until the cycle after img_done, then issued at the next busy==0.
6. Assert reset while in WAIT_DONE with 3 commands queued -> all outputs return to reset values, the FIFO is empty, and no cmd_valid appears afterward until a new push.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD subsystem: command codes and host FSM states.
package lcd_pkg;

  localparam logic [3:0] CMD_WRITE      = 4'd0;
  localparam logic [3:0] CMD_SHIFTUP    = 4'd1;
  localparam logic [3:0] CMD_SHIFTDOWN  = 4'd2;
  localparam logic [3:0] CMD_SHIFTLEFT  = 4'd3;
  localparam logic [3:0] CMD_SHIFTRIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX        = 4'd5;
  localparam logic [3:0] CMD_MIN        = 4'd6;
  localparam logic [3:0] CMD_AVERAGE    = 4'd7;
  localparam logic [3:0] CMD_ROTCCW     = 4'd8;
  localparam logic [3:0] CMD_ROTCW      = 4'd9;
  localparam logic [3:0] CMD_MIRRORX    = 4'd10;
  localparam logic [3:0] CMD_MIRRORY    = 4'd11;
  localparam logic [3:0] CMD_LAST       = 4'd11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    RUN       = 2'd2,
    WAIT_DONE = 2'd3
  } host_state_e;

  // Codes above CMD_LAST have no meaning to LCD_CTRL.
  function automatic logic is_legal_cmd(input logic [3:0] code);
    return code <= CMD_LAST;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head and registered
// occupancy count. Pushes while full and pops while empty are ignored.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       pop,
  output logic [3:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; not reset, the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_host.sv
// Host-side command initiator for LCD_CTRL: queues upstream commands and
// issues them one at a time, honouring busy and the Write/done handshake.
//
// Upstream handshake: a push happens on a clock edge where in_valid and
// in_ready are both high; in_ready depends only on current occupancy, so it
// never combinationally depends on in_valid. Illegal codes are consumed like
// any push but dropped, with bad_cmd pulsing the following cycle.
module lcd_cmd_host
  import lcd_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ACK_TO = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_cmd,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  output logic       img_done,
  output logic       bad_cmd,
  output logic       ack_err,
  output logic [7:0] issue_cnt
);

  localparam int ACW = $clog2(ACK_TO + 1);

  host_state_e    state_q;
  host_state_e    state_d;
  logic [ACW-1:0] ack_cnt_q;
  logic [3:0]     cmd_q;
  logic           cmd_valid_q;
  logic           img_done_q;
  logic           bad_cmd_q;
  logic           ack_err_q;
  logic [7:0]     issue_cnt_q;

  logic           fifo_full;
  logic           fifo_empty;
  logic [3:0]     fifo_head;
  logic           push_ok;
  logic           store;
  logic           issue;
  logic           ack_timeout;
  logic           img_seen;
  logic           last_was_write;

  assign in_ready       = !fifo_full;
  assign push_ok        = in_valid && in_ready;
  assign store          = push_ok && is_legal_cmd(in_cmd);
  assign last_was_write = (cmd_q == CMD_WRITE);

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (store),
    .push_data (in_cmd),
    .pop       (issue),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; cmd_q already holds the command in flight.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    ack_timeout = 1'b0;
    img_seen    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !busy) begin
          issue   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (busy) begin
          state_d = RUN;
        end else if (ack_cnt_q == ACW'(ACK_TO - 1)) begin
          ack_timeout = 1'b1;
          state_d     = last_was_write ? WAIT_DONE : IDLE;
        end
      end
      RUN: begin
        if (!busy) state_d = last_was_write ? WAIT_DONE : IDLE;
      end
      WAIT_DONE: begin
        if (done) begin
          img_seen = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, issue counter and ACK timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      img_done_q  <= 1'b0;
      bad_cmd_q   <= 1'b0;
      ack_err_q   <= 1'b0;
      issue_cnt_q <= '0;
      ack_cnt_q   <= '0;
    end else begin
      cmd_valid_q <= issue;
      img_done_q  <= img_seen;
      bad_cmd_q   <= push_ok && !is_legal_cmd(in_cmd);
      if (issue) cmd_q <= fifo_head;
      if (issue && issue_cnt_q != 8'hFF) issue_cnt_q <= issue_cnt_q + 8'd1;
      if (ack_timeout) ack_err_q <= 1'b1;
      if (state_q == ACK && !busy) ack_cnt_q <= ack_cnt_q + ACW'(1);
      else                         ack_cnt_q <= '0;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign img_done  = img_done_q;
  assign bad_cmd   = bad_cmd_q;
  assign ack_err   = ack_err_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Bench for lcd_cmd_host: behavioural LCD_CTRL model, expected-command
// queue popped by a monitor on every cmd_valid, directed scenarios.
module tb_lcd_cmd_host;

  logic       clk;
  logic       reset;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       img_done;
  logic       bad_cmd;
  logic       ack_err;
  logic [7:0] issue_cnt;

  logic       busy_m;
  logic       hold_busy;
  bit         ignore5;
  bit         no_done;
  int         done_delay;

  logic [3:0] exp_q[$];
  int         n_vec;
  int         n_err;
  int         cyc;
  int         img_cnt;
  int         bad_cnt;
  int         n_issue;
  int         last_issue_cyc;
  int         last_img_cyc;

  assign busy = busy_m | hold_busy;

  lcd_cmd_host #(.DEPTH(8), .ACK_TO(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_cmd    (in_cmd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .busy      (busy),
    .done      (done),
    .img_done  (img_done),
    .bad_cmd   (bad_cmd),
    .ack_err   (ack_err),
    .issue_cnt (issue_cnt)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LCD_CTRL model: busy rises one cycle after an issue, holds 3 cycles;
  // a Write is followed by done after done_delay cycles.
  initial begin
    logic [3:0] c;
    busy_m = 1'b0;
    done   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && cmd_valid) begin
        c = cmd;
        if (!(ignore5 && c == 4'd5)) begin
          @(negedge clk); #1 busy_m = 1'b1;
          repeat (3) @(negedge clk);
          #1 busy_m = 1'b0;
          if (c == 4'd0 && !no_done) begin
            repeat (done_delay) @(negedge clk);
            #1 done = 1'b1;
            @(negedge clk);
            #1 done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor / scoreboard: every issue must match the queue head while busy is low.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cmd_valid) begin
          n_issue++;
          last_issue_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_issue: got cmd %0d, expected no issue (t=%0t)", cmd, $time);
          end else begin
            e = exp_q.pop_front();
            check("issue_cmd", 32'(cmd), 32'(e));
            check("issue_busy_low", 32'(busy), 32'd0);
          end
        end
        if (img_done) begin
          img_cnt++;
          last_img_cyc = cyc;
        end
        if (bad_cmd) bad_cnt++;
      end
    end
  end

  // Drive one push at the current negedge; returns whether it was accepted.
  task automatic push(input logic [3:0] c, output bit acc);
    in_cmd   = c;
    in_valid = 1'b1;
    acc      = in_ready;
    if (acc && c <= 4'd11) exp_q.push_back(c);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    img_cnt = 0;
    bad_cnt = 0;
    n_issue = 0;
  endtask

  task automatic drain(input int max_cycles, input int settle);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (settle) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd"}, 32'(cmd), 32'd0);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_img_done"}, 32'(img_done), 32'd0);
    check({tag, "_bad_cmd"}, 32'(bad_cmd), 32'd0);
    check({tag, "_ack_err"}, 32'(ack_err), 32'd0);
    check({tag, "_issue_cnt"}, 32'(issue_cnt), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit acc;
    int n_acc;
    n_vec = 0; n_err = 0; cyc = 0;
    img_cnt = 0; bad_cnt = 0; n_issue = 0;
    last_issue_cyc = 0; last_img_cyc = 0;
    reset = 1'b1; in_cmd = '0; in_valid = 1'b0;
    hold_busy = 1'b0; ignore5 = 0; no_done = 0; done_delay = 2;

    // 1: basic issue of 1, 4, Write.
    do_reset();
    check_reset_values("reset");
    push(4'd1, acc);
    push(4'd4, acc);
    push(4'd0, acc);
    drain(200, 30);
    check("t1_img_done_pulses", 32'(img_cnt), 32'd1);
    check("t1_issue_cnt", 32'(issue_cnt), 32'd3);
    check("t1_ack_err", 32'(ack_err), 32'd0);
    check("t1_last_cmd_held", 32'(cmd), 32'd0);

    // 2: fill the FIFO with busy held high, 9th push refused.
    do_reset();
    @(negedge clk); #1 hold_busy = 1'b1;
    @(negedge clk);
    n_acc = 0;
    for (int i = 1; i <= 9; i++) begin
      push(4'(i), acc);
      if (acc) n_acc++;
      if (i == 9) check("t2_ninth_refused", 32'(acc), 32'd0);
    end
    check("t2_accepted", 32'(n_acc), 32'd8);
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    check("t2_no_issue_while_busy", 32'(issue_cnt), 32'd0);
    #1 hold_busy = 1'b0;
    drain(500, 10);
    check("t2_issue_cnt", 32'(issue_cnt), 32'd8);
    check("t2_in_ready_after", 32'(in_ready), 32'd1);

    // 3: illegal code dropped with a bad_cmd pulse.
    do_reset();
    push(4'd13, acc);
    check("t3_bad_cmd_pulse", 32'(bad_cmd), 32'd1);
    push(4'd2, acc);
    check("t3_bad_cmd_single", 32'(bad_cmd), 32'd0);
    drain(200, 10);
    check("t3_bad_cnt", 32'(bad_cnt), 32'd1);
    check("t3_issue_cnt", 32'(issue_cnt), 32'd1);

    // 4: ACK timeout on cmd 5, next command still issued.
    do_reset();
    ignore5 = 1;
    push(4'd5, acc);
    push(4'd6, acc);
    for (int i = 0; i < 50; i++) begin
      if (issue_cnt != 8'd0) break;
      @(negedge clk);
    end
    check("t4_first_issue", 32'(issue_cnt), 32'd1);
    check("t4_ack_err_at_issue", 32'(ack_err), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_ack_err_before_to", 32'(ack_err), 32'd0);
    @(negedge clk);
    check("t4_ack_err_set", 32'(ack_err), 32'd1);
    drain(200, 20);
    check("t4_issue_cnt", 32'(issue_cnt), 32'd2);
    check("t4_ack_err_sticky", 32'(ack_err), 32'd1);
    check("t4_no_img_done", 32'(img_cnt), 32'd0);
    ignore5 = 0;

    // 5: Write with a late done holds off the next issue.
    do_reset();
    done_delay = 20;
    push(4'd0, acc);
    push(4'd3, acc);
    drain(300, 20);
    check("t5_img_done_pulses", 32'(img_cnt), 32'd1);
    check("t5_issue_after_img", 32'(last_issue_cyc - last_img_cyc), 32'd1);
    check("t5_issue_cnt", 32'(issue_cnt), 32'd2);
    done_delay = 2;

    // 6: reset while waiting for done with three commands queued.
    do_reset();
    no_done = 1;
    push(4'd0, acc);
    push(4'd1, acc);
    push(4'd2, acc);
    push(4'd3, acc);
    repeat (20) @(negedge clk);
    check("t6_stuck_waiting", 32'(issue_cnt), 32'd1);
    do_reset();
    no_done = 0;
    check_reset_values("t6_reset");
    repeat (30) @(negedge clk);
    check("t6_no_issue_after_reset", 32'(n_issue), 32'd0);
    push(4'd7, acc);
    drain(100, 10);
    check("t6_new_issue_cnt", 32'(issue_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
